mem_bus_master: RTL

Initiator side of the RAM access interface. Accepts single load/store requests from the core over a valid/ready handshake. Drives the RAM's ReadWrite, 16-bit Address and shared tristate 32-bit Data bus with a fixed setup/access/release sequence, then returns read data or a write acknowledge. Sits between the core's load/store path and the RAM.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_bus_tristate.sv | 32 +++
 rtl/mem_bus_master.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared state encoding, bus direction constants and default widths for the RAM initiator.
package mem_bus_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic MEM_RW_READ  = 1'b1;
  localparam logic MEM_RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

endpackage

// File: rtl/mem_bus_tristate.sv
// Registered output-enable and data flop pair driving the shared RAM data bus.
// The bus is released on the edge that follows drive_i falling or reset.
module mem_bus_tristate
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              drive_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  inout  wire  [DATA_W-1:0] mem_data_io
);

  logic              oe_q;
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      oe_q   <= drive_i;
      dout_q <= data_i;
    end
  end

  assign mem_data_io = oe_q ? dout_q : 'z;
  assign data_o      = mem_data_io;

endmodule

// File: rtl/mem_bus_master.sv
// RAM access initiator: one load/store at a time through a fixed SETUP/ACCESS/DONE sequence.
// Build with MEM_BOUNDS_CHECK_EN to reject addresses >= MEM_DEPTH with resp_err and no bus access.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MEM_DEPTH   = 65536
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              busy_o,
  output logic              mem_rw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  inout  wire  [DATA_W-1:0] mem_data_io
);

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_rw_q, mem_rw_d;
  logic              ready_q, ready_d;
  logic              rv_q, rv_d;
  logic              rerr_q, rerr_d;
  logic              busy_q, busy_d;
  logic              drive_d;
  logic [DATA_W-1:0] bus_rd;
  logic              addr_oob;

  assign addr_oob = BOUNDS_EN && (64'(req_addr_i) >= 64'(MEM_DEPTH));

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    mem_rw_d = MEM_RW_READ;
    drive_d  = 1'b0;
    ready_d  = 1'b0;
    rv_d     = 1'b0;
    rerr_d   = 1'b0;
    busy_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && ready_q) begin
          state_d = SETUP;
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          err_d   = addr_oob;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      SETUP: begin
        cnt_d = 4'(WAIT_CYCLES - 1);
        if (err_q) begin
          state_d = DONE;
          rv_d    = 1'b1;
          rerr_d  = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = ACCESS;
          if (write_q) begin
            mem_rw_d = MEM_RW_WRITE;
            drive_d  = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last ACCESS edge: loads capture the bus here, stores release it.
          state_d = DONE;
          rv_d    = 1'b1;
          if (!write_q) rdata_d = bus_rd;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (write_q) begin
            mem_rw_d = MEM_RW_WRITE;
            drive_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      mem_rw_q <= MEM_RW_READ;
      ready_q  <= 1'b1;
      rv_q     <= 1'b0;
      rerr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      mem_rw_q <= mem_rw_d;
      ready_q  <= ready_d;
      rv_q     <= rv_d;
      rerr_q   <= rerr_d;
      busy_q   <= busy_d;
    end
  end

  mem_bus_tristate #(
    .DATA_W(DATA_W)
  ) u_tristate (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .drive_i    (drive_d),
    .data_i     (wdata_q),
    .data_o     (bus_rd),
    .mem_data_io(mem_data_io)
  );

  assign req_ready_o  = ready_q;
  assign resp_valid_o = rv_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = rerr_q;
  assign busy_o       = busy_q;
  assign mem_rw_o     = mem_rw_q;
  assign mem_addr_o   = addr_q;

endmodule
